// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
// Holds the next-PC source encodings, the sequencer state enum and the
// default reset/trap vectors used as parameter defaults by pc_sequenciador.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ       = 2'b00,
        SEL_DESVIO    = 2'b01,
        SEL_SALTO     = 2'b10,
        SEL_SALTO_REG = 2'b11
    } sel_fonte_e;

    typedef enum logic {
        EXECUTANDO = 1'b0,
        TRAVADO    = 1'b1
    } estado_e;

    localparam logic [31:0] PC_VETOR_RESET_PADRAO = 32'h0000_0000;
    localparam logic [31:0] PC_VETOR_TRAP_PADRAO  = 32'h0000_0080;
    localparam int          PC_PASSO_PADRAO       = 4;
    localparam int          PC_PROF_PILHA_PADRAO  = 4;

endpackage

// File: rtl/pilha_retorno.sv
// pilha_retorno: circular return-address LIFO.
// A push onto a full stack overwrites the oldest entry; a pop on an empty
// stack is ignored. Only instantiated when PC_PILHA_RETORNO_EN is defined.
module pilha_retorno #(
    parameter int LARGURA = 32,
    parameter int PROF    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empilha_i,
    input  logic               desempilha_i,
    input  logic [LARGURA-1:0] dado_i,
    output logic [LARGURA-1:0] topo_o,
    output logic               vazia_o
);

    localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int CW = $clog2(PROF + 1);

    logic [LARGURA-1:0] mem_q [PROF];
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_ant;
    logic [CW-1:0]      cnt_q;

    // ptr_q points at the next free slot; the top lives one slot behind it.
    assign ptr_ant = (ptr_q == '0) ? IW'(PROF - 1) : ptr_q - 1'b1;
    assign topo_o  = mem_q[ptr_ant];
    assign vazia_o = (cnt_q == '0);

    // Storage array: written on push only, contents need no reset.
    always_ff @(posedge clk) begin
        if (empilha_i) begin
            mem_q[ptr_q] <= dado_i;
        end
    end

    // Pointer and occupancy: wrap on push, saturate count at full depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (empilha_i) begin
            ptr_q <= (ptr_q == IW'(PROF - 1)) ? '0 : ptr_q + 1'b1;
            if (cnt_q != CW'(PROF)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (desempilha_i && !vazia_o) begin
            ptr_q <= ptr_ant;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequenciador.sv
// pc_sequenciador: program-counter unit with internal next-PC selection
// (sequential, conditional branch, absolute jump, jump register), stall,
// misaligned-target trap with a halted state and a retired-advance counter.
// Optional return-address stack enabled by defining PC_PILHA_RETORNO_EN.
module pc_sequenciador
    import pc_pkg::*;
#(
    parameter int                 LARGURA     = 32,
    parameter int                 PASSO       = PC_PASSO_PADRAO,
    parameter logic [LARGURA-1:0] VETOR_RESET = LARGURA'(PC_VETOR_RESET_PADRAO),
    parameter logic [LARGURA-1:0] VETOR_TRAP  = LARGURA'(PC_VETOR_TRAP_PADRAO),
    parameter int                 PROF_PILHA  = PC_PROF_PILHA_PADRAO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               habilita,
    input  logic [1:0]         sel_fonte,
    input  logic               desvio_tomado,
    input  logic [LARGURA-1:0] deslocamento,
    input  logic [LARGURA-1:0] alvo,
    input  logic               limpa_erro,
`ifdef PC_PILHA_RETORNO_EN
    input  logic               chamada,
    input  logic               retorno,
`endif
    output logic [LARGURA-1:0] atual_Pc,
    output logic [LARGURA-1:0] pc_mais4,
    output logic               erro_alinhamento,
    output logic [LARGURA-1:0] endereco_erro,
    output logic [31:0]        contador_instr
);

    // Low address bits that must be zero; PASSO=1 gives an empty mask, so no trap.
    localparam logic [LARGURA-1:0] MASCARA = LARGURA'(PASSO - 1);

    logic [LARGURA-1:0] pc_q;
    logic [LARGURA-1:0] pc_d;
    logic [LARGURA-1:0] end_erro_q;
    logic               erro_q;
    logic [31:0]        cont_q;
    estado_e            estado_q;
    logic               desalinhado;
    logic               avanca;

    assign pc_mais4 = pc_q + LARGURA'(PASSO);

`ifdef PC_PILHA_RETORNO_EN
    logic               empilha;
    logic               desempilha;
    logic               pilha_vazia;
    logic               usa_topo;
    logic [LARGURA-1:0] topo;

    // Stack moves only on an accepted advance, never on stall or trap.
    assign usa_topo   = retorno && !pilha_vazia;
    assign empilha    = avanca && (sel_fonte == SEL_SALTO) && chamada;
    assign desempilha = avanca && (sel_fonte == SEL_SALTO_REG) && usa_topo;

    pilha_retorno #(
        .LARGURA (LARGURA),
        .PROF    (PROF_PILHA)
    ) u_pilha (
        .clk          (clk),
        .rst          (rst),
        .empilha_i    (empilha),
        .desempilha_i (desempilha),
        .dado_i       (pc_mais4),
        .topo_o       (topo),
        .vazia_o      (pilha_vazia)
    );
`endif

    // Candidate next PC from the selected source; all adds wrap silently.
    always_comb begin
        pc_d = pc_mais4;
        case (sel_fonte)
            SEL_SEQ:    pc_d = pc_mais4;
            SEL_DESVIO: pc_d = desvio_tomado ? pc_mais4 + deslocamento : pc_mais4;
            SEL_SALTO:  pc_d = alvo;
`ifdef PC_PILHA_RETORNO_EN
            SEL_SALTO_REG: pc_d = usa_topo ? topo : alvo;
`else
            SEL_SALTO_REG: pc_d = alvo;
`endif
            default:    pc_d = pc_mais4;
        endcase
    end

    assign desalinhado = |(pc_d & MASCARA);
    assign avanca      = (estado_q == EXECUTANDO) && habilita && !desalinhado;

    // Sequencer FSM: advance or trap while running, wait for acknowledge while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= VETOR_RESET;
            erro_q     <= 1'b0;
            end_erro_q <= '0;
            cont_q     <= '0;
            estado_q   <= EXECUTANDO;
        end else begin
            case (estado_q)
                EXECUTANDO: begin
                    if (habilita) begin
                        if (!desalinhado) begin
                            pc_q   <= pc_d;
                            cont_q <= cont_q + 32'd1;
                        end else begin
                            end_erro_q <= pc_d;
                            erro_q     <= 1'b1;
                            estado_q   <= TRAVADO;
                        end
                    end
                end
                TRAVADO: begin
                    if (limpa_erro) begin
                        pc_q     <= VETOR_TRAP;
                        erro_q   <= 1'b0;
                        estado_q <= EXECUTANDO;
                    end
                end
                default: estado_q <= EXECUTANDO;
            endcase
        end
    end

    assign atual_Pc         = pc_q;
    assign erro_alinhamento = erro_q;
    assign endereco_erro    = end_erro_q;
    assign contador_instr   = cont_q;

endmodule

// File: tb/tb_pc_sequenciador.sv
// tb_pc_sequenciador: directed plus random stimulus for pc_sequenciador,
// compared every cycle against a behavioural model of the PC rules.
// Return-stack steps are included when PC_PILHA_RETORNO_EN is defined.
module tb_pc_sequenciador;

    localparam logic [31:0] V_RESET  = 32'h0000_0000;
    localparam logic [31:0] V_TRAP   = 32'h0000_0080;
    localparam logic [31:0] PASSO_TB = 32'd4;
    localparam int          PROF_TB  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilita;
    logic [1:0]  selFonte;
    logic        desvioTomado;
    logic [31:0] deslocamento;
    logic [31:0] alvo;
    logic        limpaErro;
    logic        chamada;
    logic        retorno;

    logic [31:0] atualPc;
    logic [31:0] pcMais4;
    logic        erroAlin;
    logic [31:0] enderecoErro;
    logic [31:0] contadorInstr;

    int nAssert = 0;
    int nFail   = 0;

    // Behavioural model state
    logic [31:0] mPc;
    logic [31:0] mEnd;
    logic [31:0] mCnt;
    bit          mTrav;
    logic [31:0] mPilha[$];

    pc_sequenciador dut (
        .clk              (clk),
        .rst              (rst),
        .habilita         (habilita),
        .sel_fonte        (selFonte),
        .desvio_tomado    (desvioTomado),
        .deslocamento     (deslocamento),
        .alvo             (alvo),
        .limpa_erro       (limpaErro),
`ifdef PC_PILHA_RETORNO_EN
        .chamada          (chamada),
        .retorno          (retorno),
`endif
        .atual_Pc         (atualPc),
        .pc_mais4         (pcMais4),
        .erro_alinhamento (erroAlin),
        .endereco_erro    (enderecoErro),
        .contador_instr   (contadorInstr)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void modelStep();
        logic [31:0] prox;
        if (rst) begin
            mPc   = V_RESET;
            mEnd  = 32'h0;
            mCnt  = 32'h0;
            mTrav = 1'b0;
            mPilha.delete();
        end else if (mTrav) begin
            if (limpaErro) begin
                mPc   = V_TRAP;
                mTrav = 1'b0;
            end
        end else if (habilita) begin
            case (selFonte)
                2'd0:    prox = mPc + PASSO_TB;
                2'd1:    prox = mPc + PASSO_TB + (desvioTomado ? deslocamento : 32'h0);
                2'd2:    prox = alvo;
                default: begin
                    prox = alvo;
`ifdef PC_PILHA_RETORNO_EN
                    if (retorno && mPilha.size() > 0) prox = mPilha[$];
`endif
                end
            endcase
            if (prox % PASSO_TB == 32'h0) begin
`ifdef PC_PILHA_RETORNO_EN
                if (selFonte == 2'd2 && chamada) begin
                    if (mPilha.size() == PROF_TB) void'(mPilha.pop_front());
                    mPilha.push_back(mPc + PASSO_TB);
                end
                if (selFonte == 2'd3 && retorno && mPilha.size() > 0) void'(mPilha.pop_back());
`endif
                mPc  = prox;
                mCnt = mCnt + 32'd1;
            end else begin
                mTrav = 1'b1;
                mEnd  = prox;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("pc", atualPc, mPc);
        chk("pc_mais4", pcMais4, mPc + PASSO_TB);
        chk("erro_alinhamento", {31'h0, erroAlin}, {31'h0, mTrav});
        chk("endereco_erro", enderecoErro, mEnd);
        chk("contador_instr", contadorInstr, mCnt);
    endtask

    task automatic applyStimulus(input bit r, input bit h, input logic [1:0] s, input bit t,
                                 input logic [31:0] d, input logic [31:0] a, input bit l,
                                 input bit c, input bit rt);
        rst          = r;
        habilita     = h;
        selFonte     = s;
        desvioTomado = t;
        deslocamento = d;
        alvo         = a;
        limpaErro    = l;
        chamada      = c;
        retorno      = rt;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;

        // Reset with a conflicting jump request pending
        applyStimulus(1, 1, 2'd2, 0, 32'h0, 32'hAAAAAAAA, 0, 0, 0);
        applyStimulus(1, 1, 2'd2, 0, 32'h0, 32'hAAAAAAAA, 0, 0, 0);
        chk("reset_pc", atualPc, 32'h0);
        chk("reset_cnt", contadorInstr, 32'h0);

        // Sequential advance
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("seq1", atualPc, 32'h4);
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("seq2", atualPc, 32'h8);
        chk("seq_cnt", contadorInstr, 32'd2);

        // Branch taken backwards, then not taken
        applyStimulus(0, 1, 2'd1, 1, 32'hFFFFFFF8, 32'h0, 0, 0, 0);
        chk("br_taken", atualPc, 32'h4);
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(0, 1, 2'd1, 0, 32'hFFFFFFF8, 32'h0, 0, 0, 0);
        chk("br_not_taken", atualPc, 32'hC);

        // Stall for three cycles, then the held jump goes through
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'd2, 0, 32'h0, 32'h40, 0, 0, 0);
        chk("stall_pc", atualPc, 32'hC);
        chk("stall_cnt", contadorInstr, 32'd5);
        applyStimulus(0, 1, 2'd2, 0, 32'h0, 32'h40, 0, 0, 0);
        chk("jump", atualPc, 32'h40);

        // Trap acknowledge while running has no effect
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 1, 0, 0);
        chk("limpa_ignored", atualPc, 32'h44);

        // Misaligned jump traps, halts, then is cleared to the trap vector
        applyStimulus(0, 1, 2'd2, 0, 32'h0, 32'h42, 0, 0, 0);
        chk("trap_pc", atualPc, 32'h44);
        chk("trap_flag", {31'h0, erroAlin}, 32'h1);
        chk("trap_addr", enderecoErro, 32'h42);
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("halted_pc", atualPc, 32'h44);
        applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 0, 0);
        chk("clear_pc", atualPc, 32'h80);
        chk("clear_flag", {31'h0, erroAlin}, 32'h0);
        chk("clear_addr_kept", enderecoErro, 32'h42);

        // Wrap-around at the top of the address space
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'hFFFFFFFC, 0, 0, 0);
        applyStimulus(0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("wrap", atualPc, 32'h0);

        // Reset while halted
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h1, 0, 0, 0);
        chk("trap2_flag", {31'h0, erroAlin}, 32'h1);
        applyStimulus(1, 1, 2'd0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("rst_halt_pc", atualPc, 32'h0);
        chk("rst_halt_flag", {31'h0, erroAlin}, 32'h0);

`ifdef PC_PILHA_RETORNO_EN
        // Call and return
        applyStimulus(0, 1, 2'd2, 0, 32'h0, 32'h10, 0, 0, 0);
        applyStimulus(0, 1, 2'd2, 0, 32'h0, 32'h100, 0, 1, 0);
        chk("call", atualPc, 32'h100);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h700, 0, 0, 1);
        chk("ret", atualPc, 32'h14);

        // Five nested calls overflow a four-deep stack
        for (int k = 1; k <= 5; k++) applyStimulus(0, 1, 2'd2, 0, 32'h0, 32'h1000 * k, 0, 1, 0);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h600, 0, 0, 1);
        chk("ret1", atualPc, 32'h4004);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h600, 0, 0, 1);
        chk("ret2", atualPc, 32'h3004);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h600, 0, 0, 1);
        chk("ret3", atualPc, 32'h2004);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h600, 0, 0, 1);
        chk("ret4", atualPc, 32'h1004);
        applyStimulus(0, 1, 2'd3, 0, 32'h0, 32'h600, 0, 0, 1);
        chk("ret_empty", atualPc, 32'h600);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rd = $urandom();
            ra = $urandom();
            if ($urandom_range(0, 7) != 0) rd = rd & 32'hFFFFFFFC;
            if ($urandom_range(0, 7) != 0) ra = ra & 32'hFFFFFFFC;
            applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, ra,
                          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/pc_sequenciador.md
Name: pc_sequenciador

Overview:
- Parametrised program-counter unit for the processor core; successor to the plain PC register.
- Holds the current PC and selects the next PC internally: sequential, conditional branch, absolute jump or jump-register.
- Adds stall, a misaligned-target trap with a halt state, and a retired-instruction counter.
- Sits between instruction fetch (drives atual_Pc) and the control/ALU path (supplies selection, offset and target).

Parameters:
- LARGURA, 32, PC/address width in bits.
- PASSO, 4, sequential increment in bytes; power of 2. Alignment mask is log2(PASSO) low bits.
- VETOR_RESET, 32'h00000000, PC value loaded on rst.
- VETOR_TRAP, 32'h00000080, PC value loaded when a trap is cleared.
- PROF_PILHA, 4, return-stack depth; used only with PC_PILHA_RETORNO_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- habilita  in  1  1 = PC may advance this cycle; 0 = stall/hold.
- sel_fonte  in  2  00 seq, 01 branch, 10 absolute jump, 11 jump register.
- desvio_tomado  in  1  branch condition; only meaningful with sel_fonte=01.
- deslocamento  in  LARGURA  sign-extended byte offset for branches.
- alvo  in  LARGURA  jump target for sel_fonte 10/11.
- limpa_erro  in  1  acknowledges a trap.
- atual_Pc  out  LARGURA  current PC (registered).
- pc_mais4  out  LARGURA  combinational atual_Pc+PASSO (link value).
- erro_alinhamento  out  1  registered; high while in TRAVADO.
- endereco_erro  out  LARGURA  offending target captured on trap.
- contador_instr  out  32  retired-advance count.

Behaviour:
- Reset (rst=1 at a clock edge):
  - atual_Pc=VETOR_RESET, erro_alinhamento=0, endereco_erro=0, contador_instr=0, state=EXECUTANDO, return stack empty.
  - rst dominates every other input.
- Candidate next PC:
  - 00: pc_mais4.
  - 01: desvio_tomado ? pc_mais4+deslocamento : pc_mais4.
  - 10 and 11: alvo. The two encodings are functionally identical except with the optional feature.
  - All adds are modulo 2^LARGURA; wrap-around is silent.
- EXECUTANDO, habilita=1:
  - If candidate[log2(PASSO)-1:0]==0: atual_Pc<=candidate and contador_instr increments, wrapping at 2^32.
  - Else: atual_Pc holds, endereco_erro<=candidate, erro_alinhamento<=1, state<=TRAVADO, and the counter does not increment.
  - The sequential path is never misaligned from an aligned PC.
- EXECUTANDO, habilita=0: all state holds; no trap check is made.
- TRAVADO:
  - atual_Pc holds regardless of habilita.
  - limpa_erro=1 at an edge: atual_Pc<=VETOR_TRAP, erro_alinhamento<=0, state<=EXECUTANDO. endereco_erro keeps its value until the next trap.
- limpa_erro in EXECUTANDO is ignored.
- Latency: one cycle from select/inputs to new atual_Pc. pc_mais4 has zero latency.
- PASSO=1: the alignment check is disabled and the block never traps.

Optional Feature:
- Macro: PC_PILHA_RETORNO_EN.
- Enabled:
  - Extra inputs chamada and retorno, 1 bit each.
  - Accepted advance with sel_fonte=10 and chamada=1: pushes pc_mais4.
  - Accepted advance with sel_fonte=11 and retorno=1: uses the popped top instead of alvo.
  - Depth PROF_PILHA, circular: push when full overwrites the oldest entry.
  - Pop when empty falls back to alvo.
  - Stack is unchanged on stall or trap.
- Disabled: no extra ports; 10 and 11 both use alvo.

Decomposition:
- Package pc_pkg:
  - sel_fonte encodings: SEL_SEQ, SEL_DESVIO, SEL_SALTO, SEL_SALTO_REG.
  - State enum: EXECUTANDO, TRAVADO.
  - Default vectors.
- One sub-module: pilha_retorno (circular LIFO), instantiated only under PC_PILHA_RETORNO_EN.

Test Plan:
- rst=1 for 2 edges with sel_fonte=10, alvo=32'hAAAAAAAA -> atual_Pc=0, contador_instr=0. Release, sel=00 for 2 cycles -> 4, then 8; count=2.
- PC=8, sel=01, deslocamento=32'hFFFFFFF8, desvio_tomado=1 -> 4. Same inputs with desvio_tomado=0 -> 32'hC.
- habilita=0 for 3 cycles at PC=32'hC with sel=10, alvo=32'h40 -> PC stays 32'hC, count unchanged. habilita=1 -> 32'h40.
- sel=10, alvo=32'h42 -> PC holds, erro_alinhamento=1, endereco_erro=32'h42. 2 cycles of habilita=1 -> PC unchanged. limpa_erro=1 -> PC=32'h80, erro=0.
- PC=32'hFFFFFFFC, sel=00 -> wraps to 0. rst asserted while in TRAVADO -> PC=0, erro=0.
- Under PC_PILHA_RETORNO_EN:
  - PC=32'h10, call to 32'h100, then return -> PC=32'h14.
  - 5 calls with depth 4, then 5 returns -> 4 correct links in LIFO order; the 5th return uses alvo.
